systolic_seq_ctrl: RTL and testbench
====================================

Name: systolic_seq_ctrl

Overview:
Sequencer for a DIM x DIM systolic array of signed MAC cells, where each cell has en, WrEn and an accumulating C register. One start pulse runs a full matrix operation: optional C preload, then the skewed A/B feed with MAC enable, then row-by-row C readout, then a done pulse. The block drives only control and index signals; A/B/C storage and the data muxes live in the surrounding datapath.

Parameters:
DIM, 8, array dimension (rows = cols = DIM); legal range 2..64
ROW_W, $clog2(DIM), width of row/column indices
CNT_W, $clog2(3*DIM), width of the phase counter

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  begin operation; sampled only in IDLE
load_c  in  1  sampled with start; 1 = run the C preload phase first
stall  in  1  freeze LOADC/FEED/READ progress this cycle
busy  out  1  operation in progress
done  out  1  one-cycle completion pulse
c_wr_en  out  1  drives WrEn of every cell in row c_row
mac_en  out  1  drives en of all cells
c_row  out  ROW_W  row index for C preload and readout
feed_k  out  CNT_W  FEED cycle count; row i / col i consume element k = feed_k - i
skew_mask  out  DIM  bit i = row i A input and col i B input carry valid data, else datapath drives 0
rd_valid  out  1  C row c_row is presented on the readout bus

Behaviour:
- Reset (async, immediate): state=IDLE, cnt=0; every output 0.
- States: IDLE, LOADC, FEED, READ, DONE. cnt resets to 0 on every state entry.
- IDLE: when start=1 at edge t, state at t+1 is LOADC if load_c=1, else FEED. Other inputs are ignored.
- LOADC: lasts DIM cycles (cnt 0..DIM-1); c_wr_en=1; c_row=cnt. Next state is FEED.
- FEED: lasts 3*DIM-2 cycles (cnt 0..3*DIM-3), which covers the last product reaching cell (DIM-1,DIM-1).
  - mac_en=1 throughout.
  - feed_k=cnt.
  - skew_mask[i]=1 iff i <= cnt <= i+DIM-1.
  - Next state is READ.
- READ: lasts DIM cycles; rd_valid=1; c_row=cnt. Next state is DONE.
- DONE: lasts one cycle; done=1, busy=1. Next state is IDLE.
- busy=1 in all states except IDLE.
- Outputs not listed for a state are 0.
- c_wr_en and mac_en are never both 1. The cell gives en priority over WrEn, so overlap would corrupt the preload.
- stall=1 in LOADC/FEED/READ:
  - cnt and state hold.
  - c_wr_en, mac_en and rd_valid are forced 0 that cycle.
  - c_row, feed_k and skew_mask hold their values.
  - Stall gating is the only combinational input-to-output path. All other outputs decode registered state/cnt only.
  - stall has no effect in IDLE or DONE.
- start while busy is ignored and is not queued.
- The block performs no arithmetic on data. The accumulator width rule (BITS_C) belongs to the datapath; the controller only guarantees exactly DIM valid products per cell per run.
- Reset asserted mid-operation aborts to IDLE at once with no done pulse. Array C contents are undefined afterwards and must be reloaded or cleared by the next run.

Test Plan:
- DIM=4, start+load_c=1 at cycle 0 -> c_wr_en 1-4 (c_row 0..3), mac_en 5-14, rd_valid 15-18 (c_row 0..3), done only at 19, busy 1-19.
- DIM=4, start, load_c=0 at cycle 0 -> no c_wr_en; FEED 1-10; skew_mask=0001 at feed_k=0, 1111 at feed_k=3, 1000 at feed_k=6, 0000 at feed_k=7..9; done at 15.
- DIM=4, no load_c, stall=1 at cycles 3-5 -> mac_en=0 and feed_k frozen at 2 for those cycles; done at 18; total mac_en-high cycles still 10.
- Start re-pulsed at cycles 4 and 15 of a run -> ignored; exactly one done; next start at 16 (IDLE) accepted.
- rst_n low at cycle 6 mid-FEED -> all outputs 0 in same cycle, no done; start after release runs a clean full sequence.
- Random load_c/stall/start over 1000 runs, DIM=2 and 8 -> assertion: c_wr_en&mac_en never 1; skew_mask high exactly DIM non-stalled cycles per bit per run.

Source files
------------

// File: rtl/systolic_seq_ctrl.sv
// Control sequencer for a DIM x DIM systolic MAC array.
// Steps through C preload, skewed A/B feed, C readout and a done pulse.
module systolic_seq_ctrl #(
    parameter int unsigned DIM   = 8,
    parameter int unsigned ROW_W = $clog2(DIM),
    parameter int unsigned CNT_W = $clog2(3 * DIM)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             load_c,
    input  logic             stall,
    output logic             busy,
    output logic             done,
    output logic             c_wr_en,
    output logic             mac_en,
    output logic [ROW_W-1:0] c_row,
    output logic [CNT_W-1:0] feed_k,
    output logic [DIM-1:0]   skew_mask,
    output logic             rd_valid
);

    typedef enum logic [2:0] {
        StIdle,
        StLoadC,
        StFeed,
        StRead,
        StDone
    } state_e;

    localparam logic [CNT_W-1:0] RowLast  = CNT_W'(DIM - 1);
    localparam logic [CNT_W-1:0] FeedLast = CNT_W'(3 * DIM - 3);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [ROW_W-1:0] row_idx;
    logic [DIM-1:0]   feed_mask;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Every phase transition clears cnt; a stalled cycle leaves both registers untouched.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = load_c ? StLoadC : StFeed;
                    cnt_d   = '0;
                end
            end
            StLoadC: begin
                if (!stall) begin
                    if (cnt_q == RowLast) begin
                        state_d = StFeed;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            StFeed: begin
                if (!stall) begin
                    if (cnt_q == FeedLast) begin
                        state_d = StRead;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            StRead: begin
                if (!stall) begin
                    if (cnt_q == RowLast) begin
                        state_d = StDone;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase
    end

    assign row_idx = cnt_q[ROW_W-1:0];

    // Row/col i sees valid operands for DIM consecutive feed cycles starting at cnt = i.
    always_comb begin
        feed_mask = '0;
        for (int unsigned i = 0; i < DIM; i++) begin
            feed_mask[i] = (32'(cnt_q) >= i) && (32'(cnt_q) <= i + DIM - 1);
        end
    end

    // Only the enables see stall combinationally; indices decode registered state alone.
    always_comb begin
        busy      = (state_q != StIdle);
        done      = 1'b0;
        c_wr_en   = 1'b0;
        mac_en    = 1'b0;
        rd_valid  = 1'b0;
        c_row     = '0;
        feed_k    = '0;
        skew_mask = '0;
        unique case (state_q)
            StLoadC: begin
                c_wr_en = !stall;
                c_row   = row_idx;
            end
            StFeed: begin
                mac_en    = !stall;
                feed_k    = cnt_q;
                skew_mask = feed_mask;
            end
            StRead: begin
                rd_valid = !stall;
                c_row    = row_idx;
            end
            StDone: begin
                done = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_systolic_seq_ctrl.sv
// Bench for systolic_seq_ctrl: DIM=4 directed table with scoreboard, plus
// randomized runs on DIM=2 and DIM=8 instances.
module tb_systolic_seq_ctrl;

    localparam int D = 4;

    typedef struct packed {
        logic       busy;
        logic       done;
        logic       c_wr_en;
        logic       mac_en;
        logic [1:0] c_row;
        logic [3:0] feed_k;
        logic [3:0] skew_mask;
        logic       rd_valid;
    } out_t;

    typedef struct {
        logic rst_n;
        logic start;
        logic load_c;
        logic stall;
        out_t exp;
    } vec_t;

    logic clk;
    logic rst_n, start, load_c, stall;
    logic busy, done, c_wr_en, mac_en, rd_valid;
    logic [1:0] c_row;
    logic [3:0] feed_k, skew_mask;

    logic       rr_n;
    logic [1:0] start_r, load_r, stall_r, busy_r, done_r, cwe_r, mac_r, rdv_r;
    logic [0:0] r2_row;
    logic [2:0] r2_fk, r8_row;
    logic [4:0] r8_fk;
    logic [1:0] mask2;
    logic [7:0] mask8;

    int errors = 0;
    int checks = 0;

    vec_t vecs[$];
    out_t act[$];
    out_t exp_q[$];

    systolic_seq_ctrl #(.DIM(D)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .load_c(load_c), .stall(stall),
        .busy(busy), .done(done), .c_wr_en(c_wr_en), .mac_en(mac_en), .c_row(c_row),
        .feed_k(feed_k), .skew_mask(skew_mask), .rd_valid(rd_valid)
    );

    systolic_seq_ctrl #(.DIM(2)) dut2 (
        .clk(clk), .rst_n(rr_n), .start(start_r[0]), .load_c(load_r[0]), .stall(stall_r[0]),
        .busy(busy_r[0]), .done(done_r[0]), .c_wr_en(cwe_r[0]), .mac_en(mac_r[0]),
        .c_row(r2_row), .feed_k(r2_fk), .skew_mask(mask2), .rd_valid(rdv_r[0])
    );

    systolic_seq_ctrl #(.DIM(8)) dut8 (
        .clk(clk), .rst_n(rr_n), .start(start_r[1]), .load_c(load_r[1]), .stall(stall_r[1]),
        .busy(busy_r[1]), .done(done_r[1]), .c_wr_en(cwe_r[1]), .mac_en(mac_r[1]),
        .c_row(r8_row), .feed_k(r8_fk), .skew_mask(mask8), .rd_valid(rdv_r[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, want);
        end
    endtask

    task automatic add(input logic r, input logic s, input logic l, input logic st, input int n);
        vec_t v;
        v.rst_n = r; v.start = s; v.load_c = l; v.stall = st; v.exp = '0;
        for (int i = 0; i < n; i++) vecs.push_back(v);
    endtask

    function automatic int plen(input int ph);
        case (ph)
            1: return D;
            2: return 3 * D - 2;
            3: return D;
            default: return 1;
        endcase
    endfunction

    // Expected outputs for phase ph (0 idle,1 loadc,2 feed,3 read,4 done) at position pos.
    function automatic out_t model_out(input int ph, input int pos, input logic st);
        out_t o = '0;
        o.busy     = (ph != 0);
        o.done     = (ph == 4);
        o.c_wr_en  = (ph == 1) && !st;
        o.mac_en   = (ph == 2) && !st;
        o.rd_valid = (ph == 3) && !st;
        if (ph == 1 || ph == 3) o.c_row = 2'(pos);
        if (ph == 2) begin
            o.feed_k = 4'(pos);
            for (int i = 0; i < D; i++) o.skew_mask[i] = (pos >= i) && (pos <= i + D - 1);
        end
        return o;
    endfunction

    function automatic int count(input int from, input int to, input int which);
        int n = 0;
        for (int k = from; k <= to; k++) begin
            case (which)
                0: n += int'(act[k].done);
                1: n += int'(act[k].c_wr_en);
                2: n += int'(act[k].mac_en);
                default: n += int'(act[k].busy);
            endcase
        end
        return n;
    endfunction

    task automatic rnd(input int g, input int d, input int runs);
        int   mcnt[8];
        logic [7:0] m;
        logic seen;
        for (int r = 0; r < runs; r++) begin
            @(posedge clk); #1;
            start_r[g] = 1'b1;
            load_r[g]  = 1'($urandom_range(0, 1));
            stall_r[g] = ($urandom_range(0, 15) == 0);
            for (int i = 0; i < 8; i++) mcnt[i] = 0;
            seen = 1'b0;
            for (int c = 0; c < 400 && !seen; c++) begin
                @(negedge clk);
                m = (g == 0) ? {6'b0, mask2} : mask8;
                checks++;
                if (cwe_r[g] && mac_r[g]) begin
                    errors++;
                    $display("FAIL overlap_d%0d: c_wr_en=1 mac_en=1 required not both", d);
                end
                for (int i = 0; i < d; i++) if (m[i] && !stall_r[g]) mcnt[i]++;
                if (done_r[g]) begin
                    seen = 1'b1;
                end else begin
                    @(posedge clk); #1;
                    start_r[g] = ($urandom_range(0, 3) == 0);
                    stall_r[g] = ($urandom_range(0, 15) == 0);
                end
            end
            start_r[g] = 1'b0;
            stall_r[g] = 1'b0;
            chk($sformatf("done_seen_d%0d", d), int'(seen), 1);
            for (int i = 0; i < d; i++) chk($sformatf("mask_cnt_d%0d_b%0d", d, i), mcnt[i], d);
        end
    endtask

    initial begin
        int s1, s2, s3, s4, s5;
        int ph, pos;
        out_t got, e;

        rst_n = 1'b0; start = 1'b0; load_c = 1'b0; stall = 1'b0;
        rr_n = 1'b0; start_r = '0; load_r = '0; stall_r = '0;

        add(0, 0, 0, 0, 2);
        add(1, 0, 0, 0, 1);
        add(1, 0, 0, 1, 1);
        s1 = vecs.size();
        add(1, 1, 1, 0, 1); add(1, 0, 0, 0, 21);
        s2 = vecs.size();
        add(1, 1, 0, 0, 1); add(1, 0, 0, 0, 14); add(1, 0, 0, 1, 2); add(1, 0, 0, 0, 1);
        s3 = vecs.size();
        add(1, 1, 0, 0, 1); add(1, 0, 0, 0, 2); add(1, 0, 0, 1, 3); add(1, 0, 0, 0, 14);
        s4 = vecs.size();
        add(1, 1, 0, 0, 1); add(1, 0, 0, 0, 3); add(1, 1, 1, 0, 1); add(1, 0, 0, 0, 10);
        add(1, 1, 0, 0, 2); add(1, 0, 0, 0, 17);
        s5 = vecs.size();
        add(1, 1, 0, 0, 1); add(1, 0, 0, 0, 5); add(0, 0, 0, 0, 1); add(1, 0, 0, 0, 1);
        add(1, 1, 0, 0, 1); add(1, 0, 0, 0, 17);

        ph = 0; pos = 0;
        for (int k = 0; k < vecs.size(); k++) begin
            if (!vecs[k].rst_n) begin
                ph = 0; pos = 0;
            end
            vecs[k].exp = model_out(ph, pos, vecs[k].stall);
            if (vecs[k].rst_n) begin
                if (ph == 0) begin
                    if (vecs[k].start) begin ph = vecs[k].load_c ? 1 : 2; pos = 0; end
                end else if (ph == 4) begin
                    ph = 0; pos = 0;
                end else if (!vecs[k].stall) begin
                    pos++;
                    if (pos == plen(ph)) begin ph++; pos = 0; end
                end
            end
        end

        for (int k = 0; k < vecs.size(); k++) begin
            @(posedge clk); #1;
            rst_n = vecs[k].rst_n; start = vecs[k].start;
            load_c = vecs[k].load_c; stall = vecs[k].stall;
            exp_q.push_back(vecs[k].exp);
            @(negedge clk);
            got = '{busy, done, c_wr_en, mac_en, c_row, feed_k, skew_mask, rd_valid};
            e = exp_q.pop_front();
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL vec%0d: got %h expected %h", k, got, e);
            end
            act.push_back(got);
        end

        chk("s1_done_at19", int'(act[s1 + 19].done), 1);
        chk("s1_done_count", count(s1, s1 + 21, 0), 1);
        chk("s1_cwr_count", count(s1, s1 + 21, 1), 4);
        chk("s1_mac_count", count(s1, s1 + 21, 2), 10);
        chk("s1_busy_count", count(s1, s1 + 21, 3), 19);
        chk("s1_row_first", int'(act[s1 + 1].c_row), 0);
        chk("s1_row_last", int'(act[s1 + 4].c_row), 3);
        chk("s1_mac_at5", int'(act[s1 + 5].mac_en), 1);
        chk("s1_mac_at14", int'(act[s1 + 14].mac_en), 1);
        chk("s1_rd_at15", int'(act[s1 + 15].rd_valid), 1);
        chk("s1_rdrow_at18", int'(act[s1 + 18].c_row), 3);
        chk("s2_cwr_count", count(s2, s2 + 17, 1), 0);
        chk("s2_mask_k0", int'(act[s2 + 1].skew_mask), 4'b0001);
        chk("s2_mask_k3", int'(act[s2 + 4].skew_mask), 4'b1111);
        chk("s2_mask_k6", int'(act[s2 + 7].skew_mask), 4'b1000);
        for (int k = 8; k <= 10; k++) chk("s2_mask_k7_9", int'(act[s2 + k].skew_mask), 0);
        chk("s2_done_at15", int'(act[s2 + 15].done), 1);
        for (int k = 3; k <= 5; k++) begin
            chk("s3_stall_feedk", int'(act[s3 + k].feed_k), 2);
            chk("s3_stall_mac", int'(act[s3 + k].mac_en), 0);
        end
        chk("s3_done_at18", int'(act[s3 + 18].done), 1);
        chk("s3_mac_count", count(s3, s3 + 19, 2), 10);
        chk("s4_done_count", count(s4, s4 + 33, 0), 2);
        chk("s4_idle_at16", int'(act[s4 + 16].busy), 0);
        chk("s4_busy_at17", int'(act[s4 + 17].busy), 1);
        chk("s4_done_at31", int'(act[s4 + 31].done), 1);
        chk("s5_rst_outputs", int'(act[s5 + 6]), 0);
        chk("s5_no_done", count(s5, s5 + 7, 0), 0);
        chk("s5_done_at23", int'(act[s5 + 23].done), 1);

        @(posedge clk); #1;
        rr_n = 1'b1;
        fork
            rnd(0, 2, 1000);
            rnd(1, 8, 1000);
        join

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
